// File: rtl/clk_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_div_pkg                                                   |
// | Brief    : Shared types and helpers for the programmable clock divider.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package clk_div_pkg;

   // Default divisor targets a 100 kHz strobe from the system clock.
   localparam int unsigned DIV_100K_HZ = 100_000;
   localparam int unsigned CFG_MAX_W   = 32;

   typedef struct packed {
      logic [CFG_MAX_W-1:0] div;
      logic [CFG_MAX_W-1:0] hi;
   } ch_cfg_t;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_div_ch                                                    |
// | Brief    : One divider channel: phase counter, active/pending config.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DEF_DIV = 500
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_en,
   input  logic    i_wr,
   input  ch_cfg_t i_cfg,
   output logic    o_div_out,
   output logic    o_tick
);

   localparam ch_cfg_t C_RST_CFG = '{div: CFG_MAX_W'(DEF_DIV), hi: CFG_MAX_W'(DEF_DIV >> 1)};

   logic [DIV_W-1:0] r_ph;
   ch_cfg_t          r_act;
   ch_cfg_t          r_pend;
   logic             r_pend_vld;
   logic             r_div_out;
   logic             r_tick;
   logic             w_wrap;
   logic             w_apply;

   // r_ph is the phase presented on the outputs after the next edge.
   assign w_wrap  = i_en && (CFG_MAX_W'(r_ph) == (r_act.div - CFG_MAX_W'(1)));
   assign w_apply = r_pend_vld && (w_wrap || !i_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ph       <= '0;
         r_act      <= C_RST_CFG;
         r_pend     <= C_RST_CFG;
         r_pend_vld <= 1'b0;
         r_div_out  <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         if (w_apply) begin
            r_act <= r_pend;
         end
         // A write on an apply edge stays pending for the next boundary.
         if (i_wr) begin
            r_pend     <= i_cfg;
            r_pend_vld <= 1'b1;
         end else if (w_apply) begin
            r_pend_vld <= 1'b0;
         end
         if (!i_en) begin
            r_ph      <= '0;
            r_div_out <= 1'b0;
            r_tick    <= 1'b0;
         end else begin
            r_ph      <= w_wrap ? '0 : (r_ph + DIV_W'(1));
            r_tick    <= (r_ph == '0);
            r_div_out <= (CFG_MAX_W'(r_ph) < r_act.hi);
         end
      end
   end

   assign o_div_out = r_div_out;
   assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/prog_clk_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prog_clk_div                                                  |
// | Brief    : Multi-channel programmable divider; write decode/validation.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module prog_clk_div
   import clk_div_pkg::*;
#(
   parameter int unsigned CLK_FRE = 50_000_000,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DEF_DIV = CLK_FRE / DIV_100K_HZ
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             ch_en,
   input  logic                          cfg_wr,
   input  logic [ch_w(int'(NUM_CH))-1:0] cfg_ch,
   input  logic [DIV_W-1:0]              cfg_div,
   input  logic [DIV_W-1:0]              cfg_hi,
   output logic                          cfg_err,
   output logic [NUM_CH-1:0]             div_out,
   output logic [NUM_CH-1:0]             tick
);

   if ((DEF_DIV < 2) || (64'(DEF_DIV) >= (64'd1 << DIV_W))) begin : g_bad_def_div
      $error("prog_clk_div: DEF_DIV must satisfy 2 <= DEF_DIV < 2**DIV_W");
   end
   if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
      $error("prog_clk_div: NUM_CH must be 1..16");
   end
   if ((DIV_W < 2) || (DIV_W > CFG_MAX_W)) begin : g_bad_div_w
      $error("prog_clk_div: DIV_W out of range");
   end

   logic              w_valid;
   logic              w_wr_ok;
   logic [NUM_CH-1:0] w_sel;
   ch_cfg_t           w_cfg;
   logic              r_cfg_err;

   assign w_valid = (cfg_div >= DIV_W'(2)) && (cfg_hi != '0) && (cfg_hi < cfg_div)
                    && (32'(cfg_ch) < NUM_CH);
   assign w_wr_ok = cfg_wr && w_valid;
   assign w_cfg   = '{div: CFG_MAX_W'(cfg_div), hi: CFG_MAX_W'(cfg_hi)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_wr && !w_valid;
      end
   end

   assign cfg_err = r_cfg_err;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_sel[g] = w_wr_ok && (32'(cfg_ch) == 32'(g));

      clk_div_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_en      (ch_en[g]),
         .i_wr      (w_sel[g]),
         .i_cfg     (w_cfg),
         .o_div_out (div_out[g]),
         .o_tick    (tick[g])
      );
   end

endmodule
`default_nettype wire
